alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Upstream stage for the 4-bit accumulator ALU tile. Stores a short program of ALU operations entered nibble-by-nibble through the 8-pin tile interface.
- Replays the stored program one operation per enabled clock.
- Drives a 2-bit op select, a 4-bit operand and a valid strobe that map directly onto the ALU's op-select and data inputs.

Parameters:
- DEPTH, 8, number of program entries (power of two, 2..16).
- AW, $clog2(DEPTH), program-counter and write-pointer width (derived; do not override).

Ports:
- io_in[0]  input  1  clock; all state updates on its rising edge.
- io_in[1]  input  1  reset, synchronous, active-high.
- io_in[2]  input  1  mode: 0 = LOAD, 1 = RUN.
- io_in[3]  input  1  strobe. In LOAD it is the nibble write strobe (edge-detected). In RUN it is the level-sensitive step enable "go".
- io_in[7:4]  input  4  nibble data.
- io_out[1:0]  output  2  op select to ALU.
- io_out[5:2]  output  4  operand to ALU.
- io_out[6]  output  1  valid; high for exactly the cycles an entry is issued.
- io_out[7]  output  1  status: full in LOAD, done in DONE, 0 in RUN.

Behaviour:
- Reset (sampled high at a clock edge):
  - state = LOAD; wr_ptr, count, pc, phase, stb_q, op_hold all 0.
  - All io_out = 0.
  - Program memory contents are don't-care after reset.
- Entry format, 7 bits: {halt, op[1:0], data[3:0]}.
  - Nibble 0: bits [5:4] = op, bit [6] = halt, bit [7] ignored.
  - Nibble 1: data.
- stb_q registers io_in[3] every cycle, in every state. A write event is io_in[3]=1 && stb_q=0.
- LOAD state:
  - Write event with phase=0: hold nibble 0 in op_hold; phase=1.
  - Write event with phase=1: mem[wr_ptr] = {op_hold, io_in[7:4]}; wr_ptr++, count++; phase=0.
  - Full when count==DEPTH. Write events while full are ignored entirely; phase does not advance.
  - io_out[7] = full. valid = 0. io_out[5:0] hold their last value.
  - mode=1 sampled: next state RUN, pc=0. A half-entered entry (phase=1) is discarded and phase is cleared.
- RUN state:
  - If count==0 on entry: the first RUN cycle goes to DONE with no issue.
  - go=1 sampled at an edge:
    - Register io_out[1:0]=mem[pc].op, io_out[5:2]=mem[pc].data, valid=1.
    - If pc==count-1 or the entry's halt bit is set: next state DONE. Otherwise pc++.
  - go=0: valid=0; op/data outputs hold; pc holds.
  - Issue latency: one cycle from go sampled to valid visible. Back-to-back issue at one entry per cycle while go stays high.
- DONE state:
  - valid=0; io_out[7]=1; op/data hold the last issued entry.
  - Stays in DONE until mode=0.
- Mode 1→0 from RUN or DONE, sampled at an edge:
  - Next state LOAD; wr_ptr=0, count=0, pc=0, phase=0, valid=0.
  - The next load overwrites the program.
- Simultaneous events:
  - Reset dominates everything.
  - A mode change takes effect before any strobe/go action in the same cycle; the strobe/go is ignored that cycle.
  - A mode change in RUN with go=1 issues nothing.
- Widths: pc and wr_ptr are AW bits; count is AW+1 bits so it can represent DEPTH.

Optional Feature:
- Macro: ALU_SEQ_LOOP_EN.
- Defined:
  - At the end of the program (pc==count-1, halt bit clear), pc wraps to 0 and the state stays RUN. The program repeats while go=1.
  - A halt entry still goes to DONE.
- Undefined: end of program always goes to DONE, as specified above.

Test Plan:
- Reset, mode=0, strobe 6 nibbles (0x1,0x3),(0x2,0x5),(0x3,0xA) -> count=3, io_out[7]=0, valid=0.
- Then mode=1, go=1 continuously -> on consecutive cycles io_out = 0x4D, 0x56, 0x6B (valid|data<<2|op), then DONE: io_out[6]=0, io_out[7]=1.
- Load 2 entries with halt set on entry 0 (nibble0=0x5) -> run issues only entry 0, then DONE.
- Load DEPTH+1 entries -> io_out[7]=1 after the DEPTH-th; the extra entry is not stored; run issues exactly DEPTH entries.
- Run with go toggling 1,0,1 -> valid pattern 1,0,1; pc does not advance on the go=0 cycle.
- With ALU_SEQ_LOOP_EN, 2 entries, go held high 5 cycles -> issue order e0,e1,e0,e1,e0.
- With ALU_SEQ_LOOP_EN, drop mode to 0 mid-run -> LOAD, count=0, valid=0 the next cycle.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Upstream stage for the 4-bit accumulator ALU tile. A short program of ALU
//   operations is entered nibble-by-nibble in LOAD mode, then replayed one
//   entry per enabled clock in RUN mode.
//
//   Entry format (7 bits): {halt, op[1:0], data[3:0]}
//     nibble 0 : [6] halt, [5:4] op, [7] ignored
//     nibble 1 : data
//
// Ports (8-pin tile interface):
//   io_in[0]    clock, rising edge
//   io_in[1]    synchronous active-high reset
//   io_in[2]    mode: 0 = LOAD, 1 = RUN
//   io_in[3]    LOAD: nibble write strobe (rising-edge detected)
//               RUN : level-sensitive step enable (go)
//   io_in[7:4]  nibble data
//   io_out[1:0] op select to ALU
//   io_out[5:2] operand to ALU
//   io_out[6]   valid, high for exactly the cycles an entry is issued
//   io_out[7]   status: full in LOAD, done in DONE, 0 in RUN
//
// Build option:
//   ALU_SEQ_LOOP_EN - when defined, reaching the last entry (halt clear)
//                     wraps pc to 0 and keeps running; halt still ends.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Pin decode
  logic       w_clk;
  logic       w_rst;
  logic       w_mode;
  logic       w_stb;
  logic [3:0] w_nib;

  assign w_clk  = io_in[0];
  assign w_rst  = io_in[1];
  assign w_mode = io_in[2];
  assign w_stb  = io_in[3];
  assign w_nib  = io_in[7:4];

  // State and datapath registers
  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic [AW-1:0]   r_pc;
  logic            r_phase;
  logic            r_stb_q;
  logic [2:0]      r_op_hold;
  logic [1:0]      r_op;
  logic [3:0]      r_data;
  logic            r_valid;
  logic            r_status;
  logic [6:0]      r_mem [DEPTH];

  // Next-state / next-value wires
  state_t          w_state_nxt;
  logic [AW-1:0]   w_wr_ptr_nxt;
  logic [AW:0]     w_count_nxt;
  logic [AW-1:0]   w_pc_nxt;
  logic            w_phase_nxt;
  logic [2:0]      w_op_hold_nxt;
  logic [1:0]      w_op_nxt;
  logic [3:0]      w_data_nxt;
  logic            w_valid_nxt;
  logic            w_status_nxt;
  logic            w_mem_we;
  logic [6:0]      w_mem_wdata;

  logic            w_wr_evt;
  logic            w_full;
  logic [6:0]      w_entry;
  logic            w_at_end;
  logic            w_end_done;

  assign w_wr_evt = w_stb & ~r_stb_q;
  assign w_full   = (r_count == CNT_FULL);
  assign w_entry  = r_mem[r_pc];
  assign w_at_end = (({1'b0, r_pc} + CNT_ONE) == r_count);

  // With looping enabled only a halt entry terminates the run.
`ifdef ALU_SEQ_LOOP_EN
  assign w_end_done = w_entry[6];
`else
  assign w_end_done = w_entry[6] | w_at_end;
`endif

  // State register
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a mode change always wins over strobe/go.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_mode) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (!w_mode) begin
          w_state_nxt = ST_LOAD;
        end else if (r_count == CNT_ZERO) begin
          w_state_nxt = ST_DONE;
        end else if (w_stb && w_end_done) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (!w_mode) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_wr_ptr_nxt  = r_wr_ptr;
    w_count_nxt   = r_count;
    w_pc_nxt      = r_pc;
    w_phase_nxt   = r_phase;
    w_op_hold_nxt = r_op_hold;
    w_op_nxt      = r_op;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_wdata   = {r_op_hold, w_nib};
    case (r_state)
      ST_LOAD: begin
        if (w_mode) begin
          // Leaving LOAD drops any half-entered entry.
          w_pc_nxt    = PTR_ZERO;
          w_phase_nxt = 1'b0;
        end else if (w_wr_evt && !w_full) begin
          if (!r_phase) begin
            w_op_hold_nxt = w_nib[2:0];
            w_phase_nxt   = 1'b1;
          end else begin
            w_mem_we     = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
            w_count_nxt  = r_count + CNT_ONE;
            w_phase_nxt  = 1'b0;
          end
        end else begin
          w_phase_nxt = r_phase;
        end
      end
      ST_RUN: begin
        if (!w_mode) begin
          w_wr_ptr_nxt = PTR_ZERO;
          w_count_nxt  = CNT_ZERO;
          w_pc_nxt     = PTR_ZERO;
          w_phase_nxt  = 1'b0;
        end else if (r_count == CNT_ZERO) begin
          w_valid_nxt = 1'b0;
        end else if (w_stb) begin
          w_op_nxt    = w_entry[5:4];
          w_data_nxt  = w_entry[3:0];
          w_valid_nxt = 1'b1;
          if (w_end_done) begin
            w_pc_nxt = r_pc;
          end else if (w_at_end) begin
            // Only reachable when looping is enabled.
            w_pc_nxt = PTR_ZERO;
          end else begin
            w_pc_nxt = r_pc + PTR_ONE;
          end
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      ST_DONE: begin
        if (!w_mode) begin
          w_wr_ptr_nxt = PTR_ZERO;
          w_count_nxt  = CNT_ZERO;
          w_pc_nxt     = PTR_ZERO;
          w_phase_nxt  = 1'b0;
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_wr_ptr_nxt = PTR_ZERO;
        w_count_nxt  = CNT_ZERO;
        w_pc_nxt     = PTR_ZERO;
        w_phase_nxt  = 1'b0;
      end
    endcase
    // Done is only flagged once the final issue cycle has passed.
    w_status_nxt = ((w_state_nxt == ST_LOAD) && (w_count_nxt == CNT_FULL)) ||
                   ((w_state_nxt == ST_DONE) && !w_valid_nxt);
  end

  // Datapath and output registers
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_wr_ptr  <= PTR_ZERO;
      r_count   <= CNT_ZERO;
      r_pc      <= PTR_ZERO;
      r_phase   <= 1'b0;
      r_stb_q   <= 1'b0;
      r_op_hold <= 3'b000;
      r_op      <= 2'b00;
      r_data    <= 4'h0;
      r_valid   <= 1'b0;
      r_status  <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_count   <= w_count_nxt;
      r_pc      <= w_pc_nxt;
      r_phase   <= w_phase_nxt;
      r_stb_q   <= w_stb;
      r_op_hold <= w_op_hold_nxt;
      r_op      <= w_op_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_status  <= w_status_nxt;
    end
  end

  // Program memory; contents are not reset.
  always_ff @(posedge w_clk) begin
    if (w_mem_we && !w_rst) begin
      r_mem[r_wr_ptr] <= w_mem_wdata;
    end
  end

  assign io_out = {r_status, r_valid, r_data, r_op};

endmodule
